// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch stage. Snapshots IM0..IM7 into an 8-entry
// store, then streams one instruction per cycle to the consumer while
// following branch redirects. Fetch stops on a halt word, on running past
// PC 7, or when MAX_ISSUE instructions have been accepted.
//
// Handshake: IN/PC are valid while ins_valid=1; a transfer happens on a
// rising clk edge with ins_valid=1 and ins_ready=1. While ins_valid=1 and
// ins_ready=0, IN, PC and ins_valid hold steady. br_taken/br_target are only
// looked at in a transfer cycle.
//
// Optional build macro FETCH_PERF_EN adds stall_cnt, a saturating count of
// cycles with ins_valid=1 and ins_ready=0.
module inst_fetch #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter int                MAX_ISSUE = 100
) (
  input  logic              clk,
  input  logic              RST,
  input  logic [DATA_W-1:0] IM0,
  input  logic [DATA_W-1:0] IM1,
  input  logic [DATA_W-1:0] IM2,
  input  logic [DATA_W-1:0] IM3,
  input  logic [DATA_W-1:0] IM4,
  input  logic [DATA_W-1:0] IM5,
  input  logic [DATA_W-1:0] IM6,
  input  logic [DATA_W-1:0] IM7,
  input  logic              ins_ready,
  input  logic              br_taken,
  input  logic [2:0]        br_target,
  output logic [DATA_W-1:0] IN,
  output logic [2:0]        PC,
  output logic              ins_valid,
  output logic              done,
  output logic [7:0]        issue_cnt,
  output logic [1:0]        dbg_state
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FETCH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [8:0] MAX_ISSUE_W = 9'(MAX_ISSUE);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] store_q [8];
  logic [DATA_W-1:0] store_d [8];
  logic [DATA_W-1:0] in_q, in_d;
  logic [2:0]        pc_q, pc_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [2:0]        next_pc;
  logic [8:0]        cnt_plus1;
  logic              xfer;

  assign xfer      = valid_q & ins_ready;
  assign cnt_plus1 = {1'b0, cnt_q} + 9'd1;

  // Next-state, store load and output register computation.
  always_comb begin
    state_d = state_q;
    in_d    = in_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    done_d  = done_q;
    cnt_d   = cnt_q;
    next_pc = pc_q + 3'd1;
    for (int i = 0; i < 8; i++) store_d[i] = store_q[i];
    case (state_q)
      S_IDLE: state_d = S_LOAD;
      S_LOAD: begin
        store_d[0] = IM0;
        store_d[1] = IM1;
        store_d[2] = IM2;
        store_d[3] = IM3;
        store_d[4] = IM4;
        store_d[5] = IM5;
        store_d[6] = IM6;
        store_d[7] = IM7;
        // The store is written on this same edge, so check IM0 directly.
        if (IM0 == HALT_WORD) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          in_d    = IM0;
          pc_d    = 3'd0;
          valid_d = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (xfer) begin
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
          if (br_taken) next_pc = br_target;
          // All three stop causes lead to the same DONE outcome; PC never wraps.
          if ((cnt_plus1 == MAX_ISSUE_W) ||
              (!br_taken && pc_q == 3'd7) ||
              (store_q[next_pc] == HALT_WORD)) begin
            state_d = S_DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            in_d = store_q[next_pc];
            pc_d = next_pc;
          end
        end
      end
      default: ; // S_DONE holds everything until reset
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      in_q    <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      for (int i = 0; i < 8; i++) store_q[i] <= '0;
    end else begin
      state_q <= state_d;
      in_q    <= in_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < 8; i++) store_q[i] <= store_d[i];
    end
  end

  assign IN        = in_q;
  assign PC        = pc_q;
  assign ins_valid = valid_q;
  assign done      = done_q;
  assign issue_cnt = cnt_q;
  assign dbg_state = state_q;

`ifdef FETCH_PERF_EN
  logic [15:0] stall_q, stall_d;

  // Count stalled cycles; ins_valid is low in DONE so the count freezes there.
  always_comb begin
    stall_d = stall_q;
    if (valid_q && !ins_ready && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
  end

  // Stall counter register.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch: a table-driven sequential run, hand-written
// multi-cycle sequences and randomized runs checked against a cycle model.
// Two instances share the inputs: MAX_ISSUE=100 (default) and MAX_ISSUE=10.
module tb_inst_fetch;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] im [8];
  logic        ins_ready = 1'b0;
  logic        br_taken = 1'b0;
  logic [2:0]  br_target = 3'd0;

  logic [31:0] in0, in1;
  logic [2:0]  pc0, pc1;
  logic        v0, v1, d0, d1;
  logic [7:0]  cnt0, cnt1;
  logic [1:0]  st0, st1;
`ifdef FETCH_PERF_EN
  logic [15:0] stall0, stall1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Clock and reset generation
  always #5 clk = ~clk;

  inst_fetch dut (
    .clk(clk), .RST(rst),
    .IM0(im[0]), .IM1(im[1]), .IM2(im[2]), .IM3(im[3]),
    .IM4(im[4]), .IM5(im[5]), .IM6(im[6]), .IM7(im[7]),
    .ins_ready(ins_ready), .br_taken(br_taken), .br_target(br_target),
    .IN(in0), .PC(pc0), .ins_valid(v0), .done(d0), .issue_cnt(cnt0),
    .dbg_state(st0)
`ifdef FETCH_PERF_EN
    , .stall_cnt(stall0)
`endif
  );

  inst_fetch #(.MAX_ISSUE(10)) dut_lim (
    .clk(clk), .RST(rst),
    .IM0(im[0]), .IM1(im[1]), .IM2(im[2]), .IM3(im[3]),
    .IM4(im[4]), .IM5(im[5]), .IM6(im[6]), .IM7(im[7]),
    .ins_ready(ins_ready), .br_taken(br_taken), .br_target(br_target),
    .IN(in1), .PC(pc1), .ins_valid(v1), .done(d1), .issue_cnt(cnt1),
    .dbg_state(st1)
`ifdef FETCH_PERF_EN
    , .stall_cnt(stall1)
`endif
  );

  // Reference model: one entry per instance. m_age counts edges since reset
  // release (0: nothing yet, 1: snapshot pending, 2: streaming or finished).
  int          m_age   [2];
  logic [31:0] m_store [2][8];
  logic [31:0] m_in    [2];
  int          m_pc    [2];
  bit          m_valid [2];
  bit          m_done  [2];
  int          m_cnt   [2];
  int          m_stall [2];
  int          m_max   [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_age[k] = 0; m_in[k] = '0; m_pc[k] = 0; m_valid[k] = 0;
      m_done[k] = 0; m_cnt[k] = 0; m_stall[k] = 0;
      for (int j = 0; j < 8; j++) m_store[k][j] = '0;
    end
  endtask

  task automatic model_finish(input int k);
    m_done[k]  = 1'b1;
    m_valid[k] = 1'b0;
  endtask

  // Advance the model by one rising edge with the given inputs.
  task automatic model_step(input bit rdy, input bit br, input int tgt);
    int npc;
    for (int k = 0; k < 2; k++) begin
      if (m_done[k]) continue;
      if (m_age[k] == 0) begin
        m_age[k] = 1;
      end else if (m_age[k] == 1) begin
        m_age[k] = 2;
        for (int j = 0; j < 8; j++) m_store[k][j] = im[j];
        if (im[0] == HALT) model_finish(k);
        else begin
          m_in[k] = im[0]; m_pc[k] = 0; m_valid[k] = 1'b1;
        end
      end else if (rdy) begin
        m_cnt[k] = (m_cnt[k] < 255) ? m_cnt[k] + 1 : 255;
        npc = br ? tgt : m_pc[k] + 1;
        if (m_cnt[k] == m_max[k]) model_finish(k);
        else if (npc > 7) model_finish(k);
        else if (m_store[k][npc] == HALT) model_finish(k);
        else begin
          m_pc[k] = npc; m_in[k] = m_store[k][npc];
        end
      end else begin
        if (m_stall[k] < 65535) m_stall[k]++;
      end
    end
  endtask

  // Scoreboard comparison
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("in0",  in0,          m_in[0]);
    chk("pc0",  32'(pc0),     32'(m_pc[0]));
    chk("v0",   32'(v0),      32'(m_valid[0]));
    chk("d0",   32'(d0),      32'(m_done[0]));
    chk("cnt0", 32'(cnt0),    32'(m_cnt[0]));
    chk("in1",  in1,          m_in[1]);
    chk("pc1",  32'(pc1),     32'(m_pc[1]));
    chk("v1",   32'(v1),      32'(m_valid[1]));
    chk("d1",   32'(d1),      32'(m_done[1]));
    chk("cnt1", 32'(cnt1),    32'(m_cnt[1]));
`ifdef FETCH_PERF_EN
    chk("stall0", 32'(stall0), 32'(m_stall[0]));
    chk("stall1", 32'(stall1), 32'(m_stall[1]));
`endif
  endtask

  // Driver: one clock with the current inputs, then model update and check.
  task automatic step();
    @(posedge clk);
    model_step(ins_ready, br_taken, int'(br_target));
    #1;
    check_all();
  endtask

  task automatic do_reset();
    ins_ready = 1'b0; br_taken = 1'b0; br_target = 3'd0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_seq();
    for (int j = 0; j < 8; j++) im[j] = 32'(j + 1);
  endtask

  typedef struct {
    bit          rdy;
    logic [31:0] e_in;
    logic [2:0]  e_pc;
    bit          e_v;
    bit          e_d;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t tbl [11];
  int   xfers;

  initial begin
    m_max[0] = 100;
    m_max[1] = 10;
    load_seq();
    model_reset();

    // Expected trace for IM=1..8 with ins_ready held high.
    tbl[0] = '{1'b1, 32'd0, 3'd0, 1'b0, 1'b0, 8'd0};
    for (int i = 1; i <= 8; i++) tbl[i] = '{1'b1, 32'(i), 3'(i - 1), 1'b1, 1'b0, 8'(i - 1)};
    tbl[9]  = '{1'b1, 32'd8, 3'd7, 1'b0, 1'b1, 8'd8};
    tbl[10] = '{1'b1, 32'd8, 3'd7, 1'b0, 1'b1, 8'd8};

    // Sequential run, table driven
    do_reset();
    for (int i = 0; i < 11; i++) begin
      ins_ready = tbl[i].rdy;
      step();
      chk("tbl_in",  in0,       tbl[i].e_in);
      chk("tbl_pc",  32'(pc0),  32'(tbl[i].e_pc));
      chk("tbl_v",   32'(v0),   32'(tbl[i].e_v));
      chk("tbl_d",   32'(d0),   32'(tbl[i].e_d));
      chk("tbl_cnt", 32'(cnt0), 32'(tbl[i].e_cnt));
    end

    // Backpressure at PC=2, then branch corner cases
    do_reset();
    ins_ready = 1'b1;
    repeat (4) step();
    ins_ready = 1'b0;
    repeat (3) begin
      step();
      chk("bp_in", in0, 32'd3);
      chk("bp_pc", 32'(pc0), 32'd2);
      chk("bp_v",  32'(v0), 32'd1);
    end
`ifdef FETCH_PERF_EN
    chk("bp_stall", 32'(stall0), 32'd3);
`endif
    ins_ready = 1'b1;
    step();
    chk("bp_resume_in", in0, 32'd4);
    step();
    chk("pre_br_pc", 32'(pc0), 32'd4);
    ins_ready = 1'b0; br_taken = 1'b1; br_target = 3'd1;
    step();
    chk("br_ignored_pc", 32'(pc0), 32'd4);
    chk("br_ignored_in", in0, 32'd5);
    ins_ready = 1'b1;
    step();
    chk("br_pc", 32'(pc0), 32'd1);
    chk("br_in", in0, 32'd2);
    br_taken = 1'b0;
    step();
    chk("br_next_pc", 32'(pc0), 32'd2);

    // Halt word at address 3
    load_seq();
    im[3] = HALT;
    do_reset();
    ins_ready = 1'b1;
    repeat (8) step();
    chk("halt_d",   32'(d0),   32'd1);
    chk("halt_v",   32'(v0),   32'd0);
    chk("halt_cnt", 32'(cnt0), 32'd3);
    chk("halt_pc",  32'(pc0),  32'd2);
    chk("halt_in",  in0,       32'd3);

    // Halt word at address 0: valid never rises
    load_seq();
    im[0] = HALT;
    do_reset();
    ins_ready = 1'b1;
    repeat (4) begin
      step();
      chk("h0_v", 32'(v0), 32'd0);
    end
    chk("h0_d", 32'(d0), 32'd1);

    // Branch loop PC1 -> 0 against the MAX_ISSUE=10 instance
    load_seq();
    do_reset();
    ins_ready = 1'b1;
    xfers = 0;
    repeat (30) begin
      br_taken  = m_valid[1] && m_pc[1] == 1;
      br_target = 3'd0;
      if (v1 && ins_ready) xfers++;
      step();
    end
    br_taken = 1'b0;
    chk("lim_xfers", 32'(xfers), 32'd10);
    chk("lim_d",     32'(d1),    32'd1);
    chk("lim_cnt",   32'(cnt1),  32'd10);

    // Asynchronous reset mid-stream at PC=5
    load_seq();
    do_reset();
    ins_ready = 1'b1;
    repeat (7) step();
    chk("pre_rst_pc", 32'(pc0), 32'd5);
    #2 rst = 1'b1;
    #1;
    chk("arst_in",  in0,       32'd0);
    chk("arst_pc",  32'(pc0),  32'd0);
    chk("arst_v",   32'(v0),   32'd0);
    chk("arst_d",   32'(d0),   32'd0);
    chk("arst_cnt", 32'(cnt0), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    ins_ready = 1'b1;
    step();
    chk("rel1_v", 32'(v0), 32'd0);
    step();
    chk("rel2_v",  32'(v0), 32'd1);
    chk("rel2_in", in0,     32'd1);
    chk("rel2_pc", 32'(pc0), 32'd0);

    // Randomized runs against the model
    for (int e = 0; e < 8; e++) begin
      for (int j = 0; j < 8; j++) begin
        im[j] = $urandom;
        if (j > 0 && $urandom_range(0, 9) == 0) im[j] = HALT;
      end
      do_reset();
      for (int c = 0; c < 60; c++) begin
        ins_ready = ($urandom_range(0, 3) != 0);
        br_taken  = ($urandom_range(0, 3) == 0);
        br_target = 3'($urandom_range(0, 7));
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction fetch stage sitting directly upstream of the control/datapath block. It snapshots the eight static instruction words IM0..IM7 into an internal 8x32 instruction store and sequences a 3-bit PC. It presents one instruction per cycle on IN with a valid/ready handshake, and it honours branch redirects from the consumer. It stops on a halt word, on running past PC 7, or on hitting an issue-count limit.

Parameters:
DATA_W, 32, instruction word width
HALT_WORD, 32'hFFFF_FFFF, encoding that terminates fetch; the halt word itself is not issued
MAX_ISSUE, 100, maximum instructions issued before forced DONE (guards against branch loops)

Ports:
clk  input  1  clock, rising-edge active
RST  input  1  reset, asynchronous, active-high
IM0..IM7  input  DATA_W each  instruction words; static after RST deasserts
ins_ready  input  1  consumer can accept IN this cycle
br_taken  input  1  redirect request; valid only in a handshake cycle
br_target  input  3  redirect PC
IN  output  DATA_W  instruction presented to consumer
PC  output  3  address of the instruction currently on IN
ins_valid  output  1  IN/PC hold a valid instruction
done  output  1  fetch finished; sticky until RST
issue_cnt  output  8  number of instructions accepted so far

Behaviour:
- Reset (async, RST=1): state=IDLE, PC=0, IN=0, ins_valid=0, done=0, issue_cnt=0, and the store is cleared to 0. Asserting RST mid-operation aborts immediately to these values.
- Handshake: a transfer occurs on a rising edge where ins_valid=1 and ins_ready=1. IN, PC and ins_valid are registered and stay stable while ins_valid=1 and ins_ready=0.
- FSM states: IDLE, LOAD, FETCH, DONE.
- IDLE: on the first edge after RST deasserts, go to LOAD.
- LOAD: copy IM0..IM7 into store[0..7].
  - If store[0]==HALT_WORD (compared using IM0 directly), go to DONE.
  - Otherwise IN<=IM0, PC<=0, ins_valid<=1, go to FETCH.
  - Load to first valid takes 2 cycles after reset release.
- FETCH, on a transfer:
  - issue_cnt increments (saturates at 255).
  - next_pc = br_taken ? br_target : PC+1.
  - br_taken wins over sequential increment. br_taken outside a transfer cycle is ignored.
- FETCH, next-cycle outcome after a transfer:
  - Sequential PC==7 with no branch (wrap-around): go to DONE; PC does not wrap.
  - issue_cnt+1 == MAX_ISSUE: go to DONE.
  - store[next_pc]==HALT_WORD: go to DONE.
  - Otherwise IN<=store[next_pc], PC<=next_pc, ins_valid stays 1. Throughput is one instruction per cycle with zero bubbles.
- DONE: ins_valid=0, done=1. IN and PC hold the last issued values. ins_ready and br_taken are ignored until RST.
- A branch to a halt-word address also goes to DONE.
- DONE priority order: MAX_ISSUE, then PC overflow, then halt word.

Optional Feature:
Macro FETCH_PERF_EN.
- Defined: adds output stall_cnt[15:0]. It resets to 0, increments (saturating) every cycle with ins_valid=1 and ins_ready=0, and freezes in DONE.
- Undefined: no port, no counter logic.

Test Plan:
- Sequential run: IM0..IM7 = 1..8, ins_ready=1 always -> IN = 1..8 on consecutive cycles with PC = 0..7, then done=1, ins_valid=0, issue_cnt=8.
- Backpressure: ins_ready=0 for 3 cycles while PC=2 -> IN stays 3 and PC stays 2 across the stall. With FETCH_PERF_EN defined, stall_cnt=3.
- Branch: at the transfer of PC=4, br_taken=1 and br_target=1 -> next IN=IM1 with PC=1. A br_taken pulse with ins_ready=0 -> ignored.
- Halt: IM3=32'hFFFF_FFFF -> instructions at PC 0..2 issue, then done=1 with issue_cnt=3 and PC=2. IM0=HALT_WORD -> done=1 with no valid ever asserted.
- Loop limit: MAX_ISSUE=10 and a branch from PC 1 to target 0 every time -> exactly 10 transfers, then done=1.
- Async reset mid-stream: assert RST between edges at PC=5 -> all outputs 0 immediately, without waiting for clk. After release, the sequence restarts from IM0 two cycles later.
